gb_timer: RTL
=============

Name: gb_timer

Overview:
- Game Boy DIV/TIMA/TMA/TAC timer block.
- Advances once per machine cycle, qualified by the `ce` strobe from the system clock divider.
- Keeps a 16-bit free-running system counter. Derives the selectable TIMA tick from falling edges of counter bits.
- Handles TIMA overflow with the hardware's one-cycle delayed reload, and raises the timer interrupt request to the interrupt controller.

Parameters:
- CNT_W, 16, width of internal system counter (DIV = counter[CNT_W-1:CNT_W-8]); only 16 is supported.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- ce  input  1  machine-cycle enable; all state advances only on clock edges with ce=1
- addr  input  2  register select: 0=DIV(FF04), 1=TIMA(FF05), 2=TMA(FF06), 3=TAC(FF07)
- wr_en  input  1  register write strobe; honoured only when ce=1
- wr_data  input  8  write data
- rd_data  output  8  combinational read of the selected register
- irq  output  1  timer interrupt request; one-clock pulse coincident with reload

Behaviour:
- Reset (reset=0, asynchronous):
  - counter=0, TIMA=00, TMA=00, TAC=000, state=RUN, prev_tick=0, irq=0.
  - rd_data follows addr combinationally, also during reset.
- Read map:
  - DIV = counter[15:8].
  - TIMA, TMA read as stored.
  - TAC reads {5'b11111, tac[2:0]}.
- Counter: on each ce edge, counter <= counter+1, wrapping FFFF->0000.
  - A write to DIV (any data) forces counter <= 0 instead of incrementing.
- Tick source: tick = counter[sel] & tac[2]. sel by tac[1:0]:
  - 00 -> bit 9 (every 1024 ce)
  - 01 -> bit 3 (every 16 ce)
  - 10 -> bit 5 (every 64 ce)
  - 11 -> bit 7 (every 256 ce)
- Tick edge detection:
  - prev_tick is registered on ce edges.
  - TIMA increment fires when prev_tick=1 and tick=0, evaluated from post-update counter/TAC values.
  - This deliberately reproduces the hardware glitch increments on DIV writes and on TAC writes that drop the selected bit or the enable.
- State machine (advances on ce only):
  - RUN:
    - Increment with TIMA=FF -> TIMA<=00, go to OVF.
    - Otherwise TIMA<=TIMA+1.
  - OVF (TIMA reads 00 for exactly one ce cycle):
    - Next ce edge: TIMA<=TMA, irq=1 for that clock, go to RELOAD.
    - A TIMA write during OVF cancels the overflow: TIMA<=wr_data, no irq, go to RUN.
  - RELOAD (one ce cycle):
    - TIMA writes are ignored.
    - A TMA write updates TMA and is also copied into TIMA.
    - Next ce edge: go to RUN.
- Write precedence in RUN: a TIMA write beats a same-cycle increment.
- irq:
  - Asserted only on the clock edge that performs the OVF->RELOAD transition.
  - Deasserted on the next clock regardless of ce.
  - Never asserted while reset=0.
- ce=0: no state change, writes ignored, irq low.
- Reset mid-operation: abandons OVF/RELOAD immediately, no irq.

Decomposition:
- Shared package gb_timer_pkg holds:
  - register address constants (ADDR_DIV..ADDR_TAC)
  - state encoding (ST_RUN, ST_OVF, ST_RELOAD)
  - the TAC-to-bit-select table (9,3,5,7)
- One natural sub-module: gb_timer_edge, holding the tick mux, prev_tick register and falling-edge detector.
- Counter, registers and FSM stay in gb_timer.

Test Plan:
- Reset then TAC=05, TIMA=00, 16 ce cycles -> TIMA=01; after 160 ce cycles -> TIMA=0A. DIV=00 until ce #256, then 01.
- TMA=AB, TIMA=FF, TAC=05, run to next tick -> TIMA reads 00 for one ce cycle, then AB with a single one-clock irq pulse.
- Same as previous, but write TIMA=10 during the OVF cycle -> TIMA=10, no irq, subsequent ticks continue from 10.
- Same as previous, but write TMA=5C during the RELOAD cycle (concurrent TIMA write 77 ignored) -> TIMA=5C, TMA=5C.
- TAC=05, run until counter[3]=1, then write DIV -> counter=0, DIV=00, TIMA increments once immediately. Write TAC=01 while counter[3]=1 -> one glitch increment.
- Assert reset during OVF with ce running -> all registers 00, TAC reads F8, irq never pulses. After release, TIMA counts from 00 once TAC is rewritten.

Source files
------------

// File: rtl/gb_timer_pkg.sv
// Purpose: shared constants, state encoding and TAC bit-select table for the
//          Game Boy DIV/TIMA/TMA/TAC timer.
// Ports  : none (package).
package gb_timer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned TAC_W  = 3;
   localparam int unsigned SEL_W  = 4;

   // Register select values (FF04..FF07)
   localparam logic [ADDR_W-1:0] ADDR_DIV  = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_TIMA = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_TMA  = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_TAC  = 2'd3;

   // RUN: normal counting; OVF: TIMA reads 00 pending reload; RELOAD: TMA just loaded
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_OVF    = 2'd1,
      ST_RELOAD = 2'd2
   } state_e;

   // System-counter bit whose falling edge clocks TIMA, selected by TAC[1:0]
   function automatic logic [SEL_W-1:0] tac_bit_sel(input logic [1:0] clk_sel);
      logic [SEL_W-1:0] sel;
      case (clk_sel)
         2'b00:   sel = 4'd9;
         2'b01:   sel = 4'd3;
         2'b10:   sel = 4'd5;
         default: sel = 4'd7;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gb_timer_edge.sv
// Purpose: TIMA tick mux and falling-edge detector.
// Ports  : i_clk, i_rst_n     - clock, async active-low reset
//          i_ce               - machine-cycle enable
//          i_cnt_nxt          - system counter value after this ce edge
//          i_tac_nxt          - TAC value after this ce edge
//          o_fall_c           - combinational: TIMA increment on this ce edge
module gb_timer_edge
   import gb_timer_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce,
   input  logic [CNT_W-1:0]   i_cnt_nxt,
   input  logic [TAC_W-1:0]   i_tac_nxt,
   output logic               o_fall_c
);

   logic r_prev_tick;
   logic w_tick;

   // Tick is taken from post-update counter/TAC so DIV and TAC writes can
   // produce the same spurious falling edges as the original hardware.
   assign w_tick   = i_cnt_nxt[tac_bit_sel(i_tac_nxt[1:0])] & i_tac_nxt[2];
   assign o_fall_c = i_ce & r_prev_tick & ~w_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_tick <= 1'b0;
      end else if (i_ce) begin
         r_prev_tick <= w_tick;
      end
   end

endmodule

// File: rtl/gb_timer.sv
// Purpose: Game Boy DIV/TIMA/TMA/TAC timer with delayed TIMA reload and IRQ.
// Ports  : clock, reset      - system clock, async active-low reset
//          ce                - machine-cycle enable, qualifies all state changes
//          addr              - register select (DIV, TIMA, TMA, TAC)
//          wr_en, wr_data    - register write strobe and data
//          rd_data           - combinational read of the selected register
//          irq               - one-clock timer interrupt pulse on reload
module gb_timer
   import gb_timer_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ce,
   input  logic [ADDR_W-1:0]  addr,
   input  logic               wr_en,
   input  logic [DATA_W-1:0]  wr_data,
   output logic [DATA_W-1:0]  rd_data,
   output logic               irq
);

   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_tima;
   logic [DATA_W-1:0] r_tma;
   logic [TAC_W-1:0]  r_tac;
   state_e            r_state;
   logic              r_irq;

   logic              w_wr;
   logic              w_wr_div;
   logic              w_wr_tima;
   logic              w_wr_tma;
   logic              w_wr_tac;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [TAC_W-1:0]  w_tac_nxt;
   logic              w_inc;

   // Write decode, only honoured on ce cycles
   assign w_wr      = ce & wr_en;
   assign w_wr_div  = w_wr & (addr == ADDR_DIV);
   assign w_wr_tima = w_wr & (addr == ADDR_TIMA);
   assign w_wr_tma  = w_wr & (addr == ADDR_TMA);
   assign w_wr_tac  = w_wr & (addr == ADDR_TAC);

   // Post-update values feed the edge detector
   assign w_cnt_nxt = w_wr_div ? '0 : r_cnt + CNT_W'(1);
   assign w_tac_nxt = w_wr_tac ? wr_data[TAC_W-1:0] : r_tac;

   gb_timer_edge #(
      .CNT_W (CNT_W)
   ) u_edge (
      .i_clk     (clock),
      .i_rst_n   (reset),
      .i_ce      (ce),
      .i_cnt_nxt (w_cnt_nxt),
      .i_tac_nxt (w_tac_nxt),
      .o_fall_c  (w_inc)
   );

   // Counter, registers and overflow/reload state machine
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_tima  <= '0;
         r_tma   <= '0;
         r_tac   <= '0;
         r_state <= ST_RUN;
         r_irq   <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         if (ce) begin
            r_cnt <= w_cnt_nxt;
            r_tac <= w_tac_nxt;
            if (w_wr_tma) begin
               r_tma <= wr_data;
            end
            case (r_state)
               ST_RUN: begin
                  if (w_wr_tima) begin
                     r_tima <= wr_data;
                  end else if (w_inc) begin
                     if (r_tima == 8'hFF) begin
                        r_tima  <= '0;
                        r_state <= ST_OVF;
                     end else begin
                        r_tima <= r_tima + 8'd1;
                     end
                  end
               end
               ST_OVF: begin
                  // A CPU write to TIMA here cancels the pending reload
                  if (w_wr_tima) begin
                     r_tima  <= wr_data;
                     r_state <= ST_RUN;
                  end else begin
                     r_tima  <= r_tma;
                     r_irq   <= 1'b1;
                     r_state <= ST_RELOAD;
                  end
               end
               ST_RELOAD: begin
                  // TIMA writes are lost; TMA writes propagate into TIMA
                  if (w_wr_tma) begin
                     r_tima <= wr_data;
                  end
                  r_state <= ST_RUN;
               end
               default: r_state <= ST_RUN;
            endcase
         end
      end
   end

   assign irq = r_irq;

   // Register read mux; unused TAC bits read as ones
   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_DIV:  rd_data = r_cnt[CNT_W-1 -: DATA_W];
         ADDR_TIMA: rd_data = r_tima;
         ADDR_TMA:  rd_data = r_tma;
         default:   rd_data = {5'b11111, r_tac};
      endcase
   end

endmodule
